calc_display_driver: RTL and testbench
======================================

# calc_display_driver

Downstream display stage for the small calculator. Consumes the calculator's state code `CS`, `done` flag and 3-bit `out` result, and drives a 4-digit multiplexed active-low 7-segment display plus a result-valid LED. It latches the result on each rising edge of `done`, then time-multiplexes result, state and status glyphs at a parameterised refresh rate with anti-ghosting blanking.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK`, 16: cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK < REFRESH_DIV.
- `IDLE_CS`, 4'h0: calculator state code that means idle.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `cs` in 4: calculator state code (control unit `CS`).
- `done` in 1: calculator done flag.
- `result` in 3: calculator result (`out`).
- `an` out 4: digit anodes, active low; `an[0]` is the rightmost digit.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active low.
- `led_done` out 1: high while a latched result is valid.

## Operation
- Result capture: register `done_q`. When `done && !done_q`, set `result_q <= result` and `valid <= 1`. If `done` is held high, the block captures once. It recaptures only after `done` falls and rises again.
- Valid clear: when `cs == IDLE_CS` and there is no capture this cycle, set `valid <= 0`. If a capture and `cs == IDLE_CS` occur in the same cycle, the capture wins and `valid = 1`. `result_q` is held until the next capture.
- Refresh counter `cnt` counts 0..REFRESH_DIV-1 and wraps to 0. On wrap, `scan` (2 bits) increments 0→1→2→3→0.
- Digit content per `scan`:
  - 0: hex glyph of `result_q` (0–7).
  - 1: blank.
  - 2: hex glyph of live `cs` (0–F).
  - 3: 'd' (7'b0100001) if `valid`, else '-' (7'b0111111).
- Blanking: while `cnt < BLANK`, `an = 4'b1111` and `seg = 7'b1111111`. Otherwise `an` has a single 0 at bit `scan`, and `seg` shows that digit's glyph.
- Blank glyph is 7'b1111111. Example hex glyphs: 0 = 7'b1000000, 3 = 7'b0110000, 5 = 7'b0010010, F = 7'b0001110.
- `led_done = valid`.

## Timing
- All outputs are registered.
- Reset values on the first rising `clk` with `rst` high: `an = 4'b1111`, `seg = 7'b1111111`, `led_done = 0`, `cnt = 0`, `scan = 0`, `result_q = 0`, `valid = 0`, `done_q = 0`.
- Reset asserted mid-scan or mid-capture overrides all other activity on that edge.
- Capture latency: rising `done` sampled at edge N makes `result_q` and `valid` update at N. `led_done` and the displayed glyph reflect them at edge N+1.
- `an`/`seg` lag `cnt`/`scan` by one cycle.
- First lit digit after reset: `an = 4'b1110` appears at edge BLANK+1.
- Each digit slot is REFRESH_DIV cycles: BLANK cycles dark, then REFRESH_DIV−BLANK cycles lit. A full frame is 4·REFRESH_DIV cycles.
- `cs` changes are displayed within one cycle when `scan = 2`. They are not latched.

## Structure
- Package `calc_disp_pkg` holds:
  - glyph constants `GLYPH_BLANK`, `GLYPH_DASH`, `GLYPH_D`;
  - scan index constants `DIG_RESULT = 0`, `DIG_BLANK = 1`, `DIG_STATE = 2`, `DIG_STATUS = 3`.
- One sub-module, `seg7_decode`: combinational 4-bit hex to active-low 7-segment decoder. It is instantiated once, muxed by `scan`.
- The top level instantiates `calc_display_driver` beside `control_unit` and `DP`, fed by the same `CS`/`done`/`out` nets.

## Test plan
Benches use REFRESH_DIV=4, BLANK=1 unless noted.
- Reset: hold `rst` 3 cycles with random inputs → `an = 4'b1111`, `seg = 7'b1111111`, `led_done = 0`. After release, `an` sequence per slot is 1111, then 1110×3, 1111, 1101×3, 1111, 1011×3, 1111, 0111×3, and repeats.
- Capture: `result = 5`, pulse `done` one cycle → `led_done = 1` next cycle. In slot 0, `seg = 7'b0010010`. In slot 3, `seg = 7'b0100001`.
- Held done: `done` high for 20 cycles while `result` changes 5→3 at cycle 2 → displayed result stays 5. Drop `done`, raise it with `result = 3` → digit 0 shows 7'b0110000.
- Idle clear and simultaneous event: `cs = IDLE_CS` with no capture → `led_done = 0`, slot 3 shows 7'b0111111. `cs = IDLE_CS` in the same cycle as a rising `done` with `result = 0` → `led_done = 1`, digit 0 shows 7'b1000000.
- State display: `cs = 4'hF` during slot 2 → `seg = 7'b0001110` on lit cycles. Blank cycles show 7'b1111111.
- Reset mid-operation: assert `rst` at `cnt = 2` of slot 2 after a capture → next edge shows all reset values and `led_done = 0`. The next rising `done` recaptures normally.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared glyphs and digit-slot indices for the calculator display driver.
// Glyphs are active low, bit order {g,f,e,d,c,b,a}.
package calc_disp_pkg;

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;

  localparam logic [1:0] DIG_RESULT = 2'd0;
  localparam logic [1:0] DIG_BLANK  = 2'd1;
  localparam logic [1:0] DIG_STATE  = 2'd2;
  localparam logic [1:0] DIG_STATUS = 2'd3;

endpackage

// File: rtl/calc_display_driver_seg7_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
// Output bit order {g,f,e,d,c,b,a}.
module seg7_decode (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/calc_display_driver.sv
// Latches the calculator result on each rising done and multiplexes result,
// live state and status glyphs onto a 4-digit active-low display.
module calc_display_driver
  import calc_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK       = 16,
  parameter logic [3:0]  IDLE_CS     = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cs,
  input  logic       done,
  input  logic [2:0] result,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       led_done
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cnt;
  logic [1:0]    scan;
  logic          done_q;
  logic [2:0]    result_q;
  logic          valid;
  logic          capture;

  logic [3:0]    dec_in;
  logic [6:0]    dec_seg;
  logic [6:0]    glyph;

  assign capture = done && !done_q;

  // Single decoder shared between the result and state digits.
  assign dec_in = (scan == DIG_STATE) ? cs : {1'b0, result_q};

  seg7_decode u_dec (
    .hex (dec_in),
    .seg (dec_seg)
  );

  always_comb begin
    glyph = GLYPH_BLANK;
    case (scan)
      DIG_RESULT: glyph = dec_seg;
      DIG_BLANK:  glyph = GLYPH_BLANK;
      DIG_STATE:  glyph = dec_seg;
      DIG_STATUS: glyph = valid ? GLYPH_D : GLYPH_DASH;
      default:    glyph = GLYPH_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      scan     <= 2'd0;
      done_q   <= 1'b0;
      result_q <= 3'd0;
      valid    <= 1'b0;
      an       <= 4'b1111;
      seg      <= GLYPH_BLANK;
      led_done <= 1'b0;
    end else begin
      done_q <= done;
      // A capture beats the idle clear when both land on the same edge.
      if (capture) begin
        result_q <= result;
        valid    <= 1'b1;
      end else if (cs == IDLE_CS) begin
        valid <= 1'b0;
      end

      if (cnt == CNT_MAX) begin
        cnt  <= '0;
        scan <= scan + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Anodes stay dark at the start of every slot to hide ghosting.
      if (cnt < BLANK_C) begin
        an  <= 4'b1111;
        seg <= GLYPH_BLANK;
      end else begin
        an  <= ~(4'b0001 << scan);
        seg <= glyph;
      end
      led_done <= valid;
    end
  end

endmodule

// File: tb/tb_calc_display_driver.sv
// Self-checking bench for calc_display_driver with REFRESH_DIV=4, BLANK=1.
// A cycle-count based reference model checks every edge; directed checks add fixed expectations.
module tb_calc_display_driver;

  localparam int RD = 4;
  localparam int BL = 1;
  localparam logic [3:0] IDLE = 4'h0;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cs;
  logic       done;
  logic [2:0] result;
  logic [3:0] an;
  logic [6:0] seg;
  logic       led_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: edges since last reset plus the spec-level capture state.
  int         k;
  logic       m_valid;
  logic [2:0] m_res;
  logic       m_doneq;

  calc_display_driver #(.REFRESH_DIV(RD), .BLANK(BL), .IDLE_CS(IDLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .done     (done),
    .result   (result),
    .an       (an),
    .seg      (seg),
    .led_done (led_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: predict outputs, advance, compare against the model.
  task automatic tick();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_led;
    int c;
    int s;
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_led = 1'b0;
    end else begin
      c = k % RD;
      s = (k / RD) % 4;
      e_led = m_valid;
      if (c < BL) begin
        e_an = 4'hF; e_seg = 7'h7F;
      end else begin
        e_an = ~(4'(1) << s);
        case (s)
          0: e_seg = HEX[m_res];
          1: e_seg = 7'h7F;
          2: e_seg = HEX[cs];
          default: e_seg = m_valid ? 7'b0100001 : 7'b0111111;
        endcase
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0; m_valid = 1'b0; m_res = 3'd0; m_doneq = 1'b0;
    end else begin
      if (done && !m_doneq) begin
        m_res = result; m_valid = 1'b1;
      end else if (cs == IDLE) begin
        m_valid = 1'b0;
      end
      m_doneq = done;
      k++;
    end
    chk("model_an", an, e_an);
    chk("model_seg", seg, e_seg);
    chk("model_led", led_done, e_led);
  endtask

  // Advance until the next edge will sample slot s at count c.
  task automatic wait_slot(input int s, input int c);
    int i;
    for (i = 0; i < 40; i++) begin
      if ((k % RD) == c && ((k / RD) % 4) == s) break;
      tick();
    end
    if (i == 40) begin
      n_cmp++; n_err++;
      $display("FAIL wait_slot: slot %0d cnt %0d not reached", s, c);
    end
  endtask

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       led;
  } vec_t;

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{4'hF, 7'b1111111, 1'b0};
    vecs[1]  = '{4'hE, 7'b1000000, 1'b0};
    vecs[2]  = '{4'hE, 7'b1000000, 1'b0};
    vecs[3]  = '{4'hE, 7'b1000000, 1'b0};
    vecs[4]  = '{4'hF, 7'b1111111, 1'b0};
    vecs[5]  = '{4'hD, 7'b1111111, 1'b0};
    vecs[6]  = '{4'hD, 7'b1111111, 1'b0};
    vecs[7]  = '{4'hD, 7'b1111111, 1'b0};
    vecs[8]  = '{4'hF, 7'b1111111, 1'b0};
    vecs[9]  = '{4'hB, 7'b1111001, 1'b0};
    vecs[10] = '{4'hB, 7'b1111001, 1'b0};
    vecs[11] = '{4'hB, 7'b1111001, 1'b0};
    vecs[12] = '{4'hF, 7'b1111111, 1'b0};
    vecs[13] = '{4'h7, 7'b0111111, 1'b0};
    vecs[14] = '{4'h7, 7'b0111111, 1'b0};
    vecs[15] = '{4'h7, 7'b0111111, 1'b0};

    k = 0; m_valid = 1'b0; m_res = 3'd0; m_doneq = 1'b0;

    // Reset with random inputs.
    rst = 1'b1; cs = 4'h1; done = 1'b0; result = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cs = 4'($urandom); done = 1'($urandom); result = 3'($urandom);
      tick();
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_led", led_done, 1'b0);
    end

    // Scan sequence after release, two frames.
    rst = 1'b0; cs = 4'h1; done = 1'b0; result = 3'd0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        tick();
        chk("vec_an", an, vecs[i].an);
        chk("vec_seg", seg, vecs[i].seg);
        chk("vec_led", led_done, vecs[i].led);
      end
    end

    // Single capture of 5.
    cs = 4'h2; done = 1'b1; result = 3'd5;
    tick();
    done = 1'b0;
    tick();
    chk("cap_led", led_done, 1'b1);
    wait_slot(0, 1); tick();
    chk("cap_seg0", seg, 7'b0010010);
    wait_slot(3, 1); tick();
    chk("cap_seg3", seg, 7'b0100001);

    // Held done must not recapture.
    done = 1'b1; result = 3'd5;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) result = 3'd3;
      tick();
    end
    wait_slot(0, 2); tick();
    chk("held_seg0", seg, 7'b0010010);
    done = 1'b0; tick();
    done = 1'b1; result = 3'd3; tick();
    done = 1'b0;
    wait_slot(0, 1); tick();
    chk("recap_seg0", seg, 7'b0110000);

    // Idle clear.
    cs = IDLE; tick(); tick();
    chk("idle_led", led_done, 1'b0);
    wait_slot(3, 2); tick();
    chk("idle_seg3", seg, 7'b0111111);

    // Capture and idle on the same edge.
    cs = IDLE; done = 1'b1; result = 3'd0;
    tick();
    done = 1'b0; cs = 4'h3;
    tick();
    chk("simul_led", led_done, 1'b1);
    wait_slot(0, 1); tick();
    chk("simul_seg0", seg, 7'b1000000);

    // Live state digit.
    cs = 4'hF;
    wait_slot(2, 0); tick();
    chk("state_blank_seg", seg, 7'h7F);
    chk("state_blank_an", an, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("state_seg", seg, 7'b0001110);
      chk("state_an", an, 4'b1011);
    end

    // Reset in the middle of a scan after a capture.
    done = 1'b1; result = 3'd6; cs = 4'h4; tick();
    done = 1'b0;
    wait_slot(2, 2);
    rst = 1'b1; tick();
    chk("midrst_an", an, 4'hF);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_led", led_done, 1'b0);
    rst = 1'b0;
    done = 1'b1; result = 3'd7; tick();
    done = 1'b0; tick();
    chk("post_rst_led", led_done, 1'b1);
    wait_slot(0, 1); tick();
    chk("post_rst_seg0", seg, 7'b1111000);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      cs     = ($urandom_range(0, 3) == 0) ? IDLE : 4'($urandom);
      done   = 1'($urandom);
      result = 3'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
